// File: rtl/gate_pkg.sv
// gate_pkg: shared state type and constants for the parking gate controller.
// Holds the FSM encoding, the lot size and the default tick counts.
package gate_pkg;

    localparam int NUM_VAGAS       = 8;
    localparam int DEF_OPEN_TICKS  = 380;
    localparam int DEF_CLOSE_TICKS = 95;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPEN_IN  = 2'd1,
        OPEN_OUT = 2'd2,
        CLOSING  = 2'd3
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/occupancy_counter.sv
// occupancy_counter: popcount of the spot sensors and the registered
// "lot full" flag used by the entry arbitration.
module occupancy_counter
    import gate_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_VAGAS-1:0] i_vagas,
    output logic                 o_lotado
);

    logic [3:0] w_count;
    logic       r_lotado;

    // Count occupied spots.
    always_comb begin
        w_count = '0;
        for (int i = 0; i < NUM_VAGAS; i++) begin
            w_count = w_count + 4'(i_vagas[i]);
        end
    end

    // Register the full flag, one clock behind the sensors.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lotado <= 1'b0;
        end else begin
            r_lotado <= (w_count == 4'(NUM_VAGAS));
        end
    end

    assign o_lotado = r_lotado;

endmodule

// File: rtl/gate_controller.sv
// gate_controller: parking barrier FSM with exit-first arbitration,
// passage detection and safety reopen. Open timeout built with GATE_TIMEOUT_EN.
module gate_controller
    import gate_pkg::*;
#(
    parameter int OPEN_TICKS  = DEF_OPEN_TICKS,
    parameter int CLOSE_TICKS = DEF_CLOSE_TICKS
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 tick,
    input  logic [NUM_VAGAS-1:0] vagasEstacionamento,
    input  logic                 reqEntrada,
    input  logic                 reqSaida,
    input  logic                 passagem,
    output logic                 cancelaAberta,
    output logic                 sentido,
    output logic                 ackEntrada,
    output logic                 ackSaida,
    output logic                 lotado,
    output logic                 timeoutFlag
);

    localparam int CW = $clog2(max2(OPEN_TICKS, CLOSE_TICKS) + 1);

    state_t        r_state;
    state_t        w_next;
    logic          r_ack_in;
    logic          r_ack_out;
    logic          r_sentido;
    logic          r_cancela;
    logic          r_pass_q;
    logic          r_seen;
    logic [CW-1:0] r_close_cnt;
    logic          w_lotado;
    logic          w_in_open;
    logic          w_rise;
    logic          w_fall;
    logic          w_open_zero;
    logic          w_grant_in;
    logic          w_grant_out;
    logic          w_reopen;
    logic          w_to_close;

    occupancy_counter u_occ (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_vagas  (vagasEstacionamento),
        .o_lotado (w_lotado)
    );

    assign w_in_open = (r_state == OPEN_IN) || (r_state == OPEN_OUT);
    assign w_rise    = w_in_open && passagem && !r_pass_q;
    assign w_fall    = w_in_open && r_seen && r_pass_q && !passagem;

`ifdef GATE_TIMEOUT_EN
    logic [CW-1:0] r_open_cnt;
    logic          r_timeout;

    assign w_open_zero = (r_open_cnt == '0);

    // Open timer: loaded on grant or reopen, counts ticks while open.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_open_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_grant_in || w_grant_out || w_reopen) begin
                r_open_cnt <= CW'(OPEN_TICKS);
            end else if (w_in_open && tick && !w_open_zero) begin
                r_open_cnt <= r_open_cnt - CW'(1);
            end
            if (w_grant_in || w_grant_out) begin
                r_timeout <= 1'b0;
            end else if (w_in_open && !w_fall && w_open_zero) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeoutFlag = r_timeout;
`else
    assign w_open_zero = 1'b0;
    assign timeoutFlag = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: arbitration, passage, timeout and reopen.
    always_comb begin
        w_next      = r_state;
        w_grant_in  = 1'b0;
        w_grant_out = 1'b0;
        w_reopen    = 1'b0;
        w_to_close  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (reqSaida) begin
                    w_next      = OPEN_OUT;
                    w_grant_out = 1'b1;
                end else if (reqEntrada && !w_lotado) begin
                    w_next     = OPEN_IN;
                    w_grant_in = 1'b1;
                end
            end
            OPEN_IN, OPEN_OUT: begin
                if (w_fall || w_open_zero) begin
                    w_next     = CLOSING;
                    w_to_close = 1'b1;
                end
            end
            CLOSING: begin
                if (passagem) begin
                    w_next   = r_sentido ? OPEN_OUT : OPEN_IN;
                    w_reopen = 1'b1;
                end else if (r_close_cnt == '0) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Registered outputs, passage tracking and closing timer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ack_in    <= 1'b0;
            r_ack_out   <= 1'b0;
            r_sentido   <= 1'b0;
            r_cancela   <= 1'b0;
            r_pass_q    <= 1'b0;
            r_seen      <= 1'b0;
            r_close_cnt <= '0;
        end else begin
            r_ack_in  <= w_grant_in;
            r_ack_out <= w_grant_out;
            r_cancela <= (w_next == OPEN_IN) || (w_next == OPEN_OUT);
            r_pass_q  <= passagem;
            if (w_grant_in) begin
                r_sentido <= 1'b0;
            end else if (w_grant_out) begin
                r_sentido <= 1'b1;
            end
            if (w_grant_in || w_grant_out) begin
                r_seen <= 1'b0;
            end else if (w_reopen || w_rise) begin
                r_seen <= 1'b1;
            end
            if (w_to_close) begin
                r_close_cnt <= CW'(CLOSE_TICKS);
            end else if (r_state == CLOSING && tick && r_close_cnt != '0) begin
                r_close_cnt <= r_close_cnt - CW'(1);
            end
        end
    end

    assign ackEntrada    = r_ack_in;
    assign ackSaida      = r_ack_out;
    assign sentido       = r_sentido;
    assign cancelaAberta = r_cancela;
    assign lotado        = w_lotado;

endmodule

// File: tb/tb_gate_controller.sv
// tb_gate_controller: vector table, directed corner sequences and a
// randomized run against a behavioural reference of the barrier rules.
module tb_gate_controller;

    localparam int OT = 380;
    localparam int CT = 95;
`ifdef GATE_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       tick = 1'b0;
    logic [7:0] vagasEstacionamento = 8'h0F;
    logic       reqEntrada = 1'b0;
    logic       reqSaida = 1'b0;
    logic       passagem = 1'b0;
    logic       cancelaAberta;
    logic       sentido;
    logic       ackEntrada;
    logic       ackSaida;
    logic       lotado;
    logic       timeoutFlag;

    int checks = 0;
    int errors = 0;

    gate_controller #(
        .OPEN_TICKS  (OT),
        .CLOSE_TICKS (CT)
    ) dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .tick                (tick),
        .vagasEstacionamento (vagasEstacionamento),
        .reqEntrada          (reqEntrada),
        .reqSaida            (reqSaida),
        .passagem            (passagem),
        .cancelaAberta       (cancelaAberta),
        .sentido             (sentido),
        .ackEntrada          (ackEntrada),
        .ackSaida            (ackSaida),
        .lotado              (lotado),
        .timeoutFlag         (timeoutFlag)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit cond(input int w);
        case (w)
            0:       return ackEntrada;
            1:       return ackSaida;
            2:       return cancelaAberta;
            3:       return !cancelaAberta;
            default: return timeoutFlag;
        endcase
    endfunction

    // Issue ticks (tick cycle + idle cycle) until cond(w) or budget ends.
    // n = ticks completed before the edge that produced the condition.
    task automatic tick_until(input int w, input int maxt,
                              output int n, output bit got);
        got = 1'b0;
        n   = 0;
        for (int i = 0; i < maxt && !got; i++) begin
            tick = 1'b1;
            @(negedge CLK);
            tick = 1'b0;
            if (cond(w)) begin
                got = 1'b1;
                n   = i;
            end else begin
                @(negedge CLK);
                if (cond(w)) begin
                    got = 1'b1;
                    n   = i + 1;
                end
            end
        end
    endtask

    task automatic run_ticks(input int k);
        for (int i = 0; i < k; i++) begin
            tick = 1'b1;
            @(negedge CLK);
            tick = 1'b0;
            @(negedge CLK);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        reqEntrada = 1'b0;
        reqSaida = 1'b0;
        passagem = 1'b0;
        tick = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    // Behavioural reference: where 0=down/idle, 1=up, 2=lowering.
    int m_where, m_dir, m_armed, m_prev, m_close_el, m_open_el;
    int m_tmo, m_lot, m_ain, m_aout;

    task automatic m_reset();
        m_where = 0; m_dir = 0; m_armed = 0; m_prev = 0;
        m_close_el = 0; m_open_el = 0; m_tmo = 0; m_lot = 0;
        m_ain = 0; m_aout = 0;
    endtask

    task automatic m_step(input bit rin, input bit rout, input bit pass,
                          input bit tk, input logic [7:0] vag);
        int nw;
        bit rise;
        bit fall;
        nw = m_where;
        m_ain = 0;
        m_aout = 0;
        if (m_where == 0) begin
            if (rout || (rin && m_lot == 0)) begin
                nw = 1;
                m_dir = rout ? 1 : 0;
                m_aout = rout ? 1 : 0;
                m_ain = rout ? 0 : 1;
                m_armed = 0;
                m_open_el = 0;
                m_tmo = 0;
            end
        end else if (m_where == 1) begin
            rise = pass && m_prev == 0;
            fall = !pass && m_prev == 1 && m_armed == 1;
            if (fall || (TMO && m_open_el >= OT)) begin
                nw = 2;
                m_close_el = 0;
                if (!fall) m_tmo = 1;
            end else begin
                if (rise) m_armed = 1;
                if (TMO && tk && m_open_el < OT) m_open_el++;
            end
        end else begin
            if (pass) begin
                nw = 1;
                m_armed = 1;
                m_open_el = 0;
            end else if (m_close_el >= CT) begin
                nw = 0;
            end else if (tk) begin
                m_close_el++;
            end
        end
        m_where = nw;
        m_lot = ($countones(vag) == 8) ? 1 : 0;
        m_prev = pass ? 1 : 0;
    endtask

    typedef struct {
        bit         rin;
        bit         rout;
        bit         pass;
        bit         tk;
        logic [7:0] vag;
        bit         ain;
        bit         aout;
        bit         can;
        bit         sen;
        bit         lot;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[10];
        int   n;
        bit   got;
        logic [5:0] act;
        logic [5:0] exp;

        //            rin rout pass tk vag    ain aout can sen lot
        tbl[0] = '{0, 0, 0, 0, 8'h0F, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 0, 0, 8'h0F, 1, 0, 1, 0, 0};
        tbl[2] = '{0, 0, 0, 1, 8'h0F, 0, 0, 1, 0, 0};
        tbl[3] = '{0, 0, 1, 0, 8'h0F, 0, 0, 1, 0, 0};
        tbl[4] = '{0, 0, 0, 1, 8'h0F, 0, 0, 0, 0, 0};
        tbl[5] = '{0, 1, 0, 0, 8'h0F, 0, 0, 0, 0, 0};
        tbl[6] = '{0, 1, 1, 0, 8'h0F, 0, 0, 1, 0, 0};
        tbl[7] = '{0, 0, 0, 0, 8'h0F, 0, 0, 0, 0, 0};
        tbl[8] = '{0, 0, 0, 1, 8'hFF, 0, 0, 0, 0, 1};
        tbl[9] = '{0, 0, 0, 0, 8'hFF, 0, 0, 0, 0, 1};

        // reset state
        @(negedge CLK);
        chk("rst_cancela", cancelaAberta, 0);
        chk("rst_acks", {ackEntrada, ackSaida}, 0);
        chk("rst_lot_tmo", {lotado, timeoutFlag, sentido}, 0);

        vagasEstacionamento = 8'h0F;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            reqEntrada = tbl[i].rin;
            reqSaida = tbl[i].rout;
            passagem = tbl[i].pass;
            tick = tbl[i].tk;
            vagasEstacionamento = tbl[i].vag;
            @(negedge CLK);
            chk($sformatf("vec%0d_ain", i), ackEntrada, tbl[i].ain);
            chk($sformatf("vec%0d_aout", i), ackSaida, tbl[i].aout);
            chk($sformatf("vec%0d_can", i), cancelaAberta, tbl[i].can);
            chk($sformatf("vec%0d_sen", i), sentido, tbl[i].sen);
            chk($sformatf("vec%0d_lot", i), lotado, tbl[i].lot);
        end
        tick = 1'b0;

        // simultaneous requests: exit first, entry after the close
        vagasEstacionamento = 8'h0F;
        do_reset();
        reqEntrada = 1'b1;
        reqSaida = 1'b1;
        @(negedge CLK);
        chk("arb_ack_out", ackSaida, 1);
        chk("arb_ack_in", ackEntrada, 0);
        chk("arb_sentido", sentido, 1);
        reqSaida = 1'b0;
        passagem = 1'b1;
        @(negedge CLK);
        chk("arb_ack_pulse", ackSaida, 0);
        passagem = 1'b0;
        @(negedge CLK);
        chk("arb_closing", cancelaAberta, 0);
        tick_until(0, 300, n, got);
        chk("arb_entry_got", got, 1);
        chk("arb_entry_ticks", n, CT);
        chk("arb_entry_dir", sentido, 0);
        reqEntrada = 1'b0;

        // full lot holds entry pending
        do_reset();
        vagasEstacionamento = 8'hFF;
        chk("full_lot_before", lotado, 0);
        @(negedge CLK);
        chk("full_lot_latency", lotado, 1);
        reqEntrada = 1'b1;
        tick_until(0, 1000, n, got);
        chk("full_no_ack", got, 0);
        chk("full_closed", cancelaAberta, 0);
        vagasEstacionamento = 8'hFE;
        @(negedge CLK);
        chk("free_lot", lotado, 0);
        chk("free_no_ack_yet", ackEntrada, 0);
        @(negedge CLK);
        chk("free_grant", ackEntrada, 1);
        reqEntrada = 1'b0;

        // safety reopen at tick 40 of closing
        passagem = 1'b1;
        @(negedge CLK);
        passagem = 1'b0;
        @(negedge CLK);
        chk("sr_closing", cancelaAberta, 0);
        run_ticks(40);
        chk("sr_close40", cancelaAberta, 0);
        passagem = 1'b1;
        @(negedge CLK);
        chk("sr_reopen", cancelaAberta, 1);
        chk("sr_no_ack", {ackEntrada, ackSaida}, 0);
        chk("sr_dir", sentido, 0);
        passagem = 1'b0;
        @(negedge CLK);
        chk("sr_reclose", cancelaAberta, 0);
        reqEntrada = 1'b1;
        tick_until(0, 300, n, got);
        chk("sr_got", got, 1);
        chk("sr_reload_ticks", n, CT);
        reqEntrada = 1'b0;

        // open timeout (or indefinite wait when not built)
        do_reset();
        reqSaida = 1'b1;
        @(negedge CLK);
        chk("to_grant", ackSaida, 1);
        reqSaida = 1'b0;
`ifdef GATE_TIMEOUT_EN
        tick_until(3, 600, n, got);
        chk("to_closed", got, 1);
        chk("to_ticks", n, OT);
        chk("to_flag", timeoutFlag, 1);
        reqEntrada = 1'b1;
        tick_until(0, 300, n, got);
        chk("to_next_got", got, 1);
        chk("to_next_ticks", n, CT);
        chk("to_flag_clear", timeoutFlag, 0);
        reqEntrada = 1'b0;
`else
        tick_until(3, 500, n, got);
        chk("nto_stays_open", got, 0);
        chk("nto_flag", timeoutFlag, 0);
        passagem = 1'b1;
        @(negedge CLK);
        passagem = 1'b0;
        @(negedge CLK);
        chk("nto_closing", cancelaAberta, 0);
`endif

        // reset while open drops the barrier at once
        vagasEstacionamento = 8'h0F;
        do_reset();
        reqSaida = 1'b1;
        @(negedge CLK);
        chk("mr_grant", ackSaida, 1);
        reqSaida = 1'b0;
        @(negedge CLK);
        chk("mr_open", cancelaAberta, 1);
        #2 RST = 1'b1;
        #1;
        chk("mr_async_cancela", cancelaAberta, 0);
        chk("mr_async_sentido", sentido, 0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("mr_idle", cancelaAberta, 0);
        reqEntrada = 1'b1;
        @(negedge CLK);
        chk("mr_rearb", ackEntrada, 1);
        reqEntrada = 1'b0;

        // randomized run against the reference
        reqEntrada = 1'b0;
        reqSaida = 1'b0;
        passagem = 1'b0;
        tick = 1'b0;
        vagasEstacionamento = 8'h00;
        RST = 1'b1;
        m_reset();
        @(negedge CLK);
        RST = 1'b0;
        m_step(reqEntrada, reqSaida, passagem, tick, vagasEstacionamento);
        for (int c = 0; c < 20000; c++) begin
            @(negedge CLK);
            act = {ackEntrada, ackSaida, cancelaAberta, sentido, lotado,
                   timeoutFlag};
            exp = {m_ain[0], m_aout[0], (m_where == 1), m_dir[0], m_lot[0],
                   m_tmo[0]};
            chk($sformatf("rand_c%0d", c), act, exp);
            tick = ($urandom_range(0, 3) != 0);
            if (passagem) passagem = ($urandom_range(0, 3) != 0);
            else passagem = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 29) == 0) reqEntrada = !reqEntrada;
            if ($urandom_range(0, 59) == 0) reqSaida = !reqSaida;
            if ($urandom_range(0, 49) == 0) begin
                if ($urandom_range(0, 2) == 0) vagasEstacionamento = 8'hFF;
                else vagasEstacionamento = 8'($urandom);
            end
            if ($urandom_range(0, 2999) == 0) begin
                RST = 1'b1;
                #1;
                RST = 1'b0;
                m_reset();
            end
            m_step(reqEntrada, reqSaida, passagem, tick, vagasEstacionamento);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
